// File: rtl/set_scan_ctrl.sv
// -----------------------------------------------------------------------------
// set_scan_ctrl
//  Sequencer for the circle-membership datapath of the SET engine. One job is
//  accepted per en strobe while idle. The job walks every point of the
//  GRID x GRID grid (x fastest, coordinates 1-based), one point per cycle. It
//  presents each point to the three MapCell evaluators. LAT cycles later it
//  samples their hit bits and counts the points that satisfy the job's mode
//  predicate.
//
// Ports
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous reset, active-high
//  en         in   1  job start strobe, sampled only while idle
//  mode       in   2  job predicate, captured with en
//  pt_x       out  4  current scan x coordinate (1..GRID)
//  pt_y       out  4  current scan y coordinate (1..GRID)
//  lane_en    out  3  evaluator enables {C,B,A}, zero outside SCAN
//  hit_a/b/c  in   1  evaluator results, valid LAT cycles after issue
//  busy       out  1  job in progress (SCAN, DRAIN, DONE)
//  valid      out  1  one-cycle pulse, candidate is final
//  candidate  out  8  number of qualifying points
//
// Parameters
//  LAT   evaluator latency in cycles (1..4)
//  GRID  grid edge length
// -----------------------------------------------------------------------------
// state | meaning
// ------+----------------------------------------------------------------------
// IDLE  | waiting for en; candidate holds the previous result
// SCAN  | issuing one grid point per cycle
// DRAIN | LAT cycles letting the last evaluator results arrive
// DONE  | valid pulse, candidate final
// -----------------------------------------------------------------------------
module set_scan_ctrl #(
   parameter int LAT  = 1,
   parameter int GRID = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   output logic [3:0] pt_x,
   output logic [3:0] pt_y,
   output logic [2:0] lane_en,
   input  logic       hit_a,
   input  logic       hit_b,
   input  logic       hit_c,
   output logic       busy,
   output logic       valid,
   output logic [7:0] candidate
);

   localparam int CW = (GRID > 1) ? $clog2(GRID) : 1;
   localparam int DW = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  col_q, col_d;
   logic [CW-1:0]  row_q, row_d;
   logic [1:0]     mode_q, mode_d;
   logic [DW-1:0]  drain_q, drain_d;
   logic [LAT-1:0] tag_q;
   logic [7:0]     cand_q, cand_d;

   logic accept;
   logic scan_issue;
   logic col_last;
   logic row_last;
   logic last_pt;
   logic drain_tc;
   logic tag_out;
   logic pred;

   assign accept     = (state_q == S_IDLE) && en;
   assign scan_issue = (state_q == S_SCAN);
   assign col_last   = (col_q == CW'(GRID - 1));
   assign row_last   = (row_q == CW'(GRID - 1));
   assign last_pt    = col_last && row_last;
   assign drain_tc   = (drain_q == '0);
   assign tag_out    = tag_q[LAT-1];

   // ---------------------------------------------------------------- FSM ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (en)       state_d = S_SCAN;
         S_SCAN:  if (last_pt)  state_d = S_DRAIN;
         S_DRAIN: if (drain_tc) state_d = S_DONE;
         S_DONE:                state_d = S_IDLE;
         default:               state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != S_IDLE);
      valid   = (state_q == S_DONE);
      lane_en = 3'b000;
      if (state_q == S_SCAN) begin
         case (mode_q)
            2'b00:   lane_en = 3'b001;
            2'b01,
            2'b10:   lane_en = 3'b011;
            default: lane_en = 3'b111;
         endcase
      end
   end

   // ---------------------------------------------------------- datapath ----
   // Disabled lanes never reach the predicate, so whatever the evaluators
   // drive on them is irrelevant.
   always_comb begin
      pred = 1'b0;
      case (mode_q)
         2'b00:   pred = hit_a;
         2'b01:   pred = hit_a & hit_b;
         2'b10:   pred = hit_a ^ hit_b;
         default: pred = (hit_a & hit_b & ~hit_c) |
                         (hit_a & ~hit_b & hit_c) |
                         (~hit_a & hit_b & hit_c);
      endcase
   end

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      mode_d  = mode_q;
      drain_d = drain_q;
      cand_d  = cand_q;

      if (accept) begin
         mode_d = mode;
         col_d  = '0;
         row_d  = '0;
         cand_d = '0;
      end else begin
         if (scan_issue) begin
            if (col_last) begin
               col_d = '0;
               row_d = row_last ? '0 : row_q + CW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         // Only tagged cycles carry a real evaluator result.
         if (tag_out && pred) begin
            cand_d = cand_q + 8'd1;
         end
      end

      // DRAIN down-counter: loaded with LAT-1 so DRAIN spans exactly LAT cycles.
      if (scan_issue && last_pt) begin
         drain_d = DW'(LAT - 1);
      end else if ((state_q == S_DRAIN) && !drain_tc) begin
         drain_d = drain_q - DW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         mode_q  <= 2'b00;
         drain_q <= '0;
         cand_q  <= 8'd0;
         tag_q   <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         mode_q  <= mode_d;
         drain_q <= drain_d;
         cand_q  <= cand_d;
         tag_q   <= (tag_q << 1) | LAT'(scan_issue);
      end
   end

   assign pt_x      = 4'(col_q) + 4'd1;
   assign pt_y      = 4'(row_q) + 4'd1;
   assign candidate = cand_q;

endmodule
